seg_scan: RTL and testbench

Multiplexed seven-segment display driver that sits directly downstream of the digit-to-segment-code converter. It takes a packed vector of per-digit active-low segment codes from that converter, latches it through a double buffer at frame boundaries so a scan never tears, and time-multiplexes the digits onto one shared segment bus with an active-low digit select. A blanking guard interval between digits suppresses ghosting.

---
 rtl/seg_scan_pkg.sv | 27 ++
 rtl/seg_scan_if.sv | 29 ++
 rtl/seg_scan_timer.sv | 26 ++
 rtl/seg_scan.sv | 107 ++++++++++
 tb/tb_seg_scan.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// The segment bit order is common with the upstream digit-to-segment converter.
package seg_scan_pkg;

    // Active-low segment code that lights nothing.
    localparam logic [7:0] SEG_BLANK = 8'hff;

    // Segment bit positions within a code byte: {dp,g,f,e,d,c,b,a}.
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    typedef enum logic [0:0] {
        ST_GUARD,
        ST_SHOW
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Code-in / display-out bundle between the segment converter, seg_scan and the pads.
interface seg_scan_if #(
    parameter int unsigned DIGITS = 4
);
    logic [8*DIGITS-1:0] code;
    logic                code_vld;
    logic                upd_ack;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   sel;
    logic                frame;

    modport master (
        output code,
        output code_vld,
        input  upd_ack,
        input  seg,
        input  sel,
        input  frame
    );

    modport slave (
        input  code,
        input  code_vld,
        output upd_ack,
        output seg,
        output sel,
        output frame
    );
endinterface

// File: rtl/seg_scan_timer.sv
// Phase timer: restarts from zero on load and flags the cycle where it reaches last.
module seg_scan_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] last,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    assign tc = (count_q == last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment driver: double-buffered code capture, guarded digit scan,
// registered active-low segment and digit-select outputs.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned GUARD  = 16
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);

    localparam int unsigned TW = $clog2(max_u(DIV, GUARD));
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD - 1);
    localparam logic [TW-1:0] DIV_LAST   = TW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    state_e              state_q;
    logic [IW-1:0]       idx_q;
    logic [8*DIGITS-1:0] pending_q;
    logic [8*DIGITS-1:0] shadow_q;
    logic                pend_vld_q;
    logic [7:0]          seg_q;
    logic [DIGITS-1:0]   sel_q;
    logic                frame_q;
    logic                upd_ack_q;

    logic                tmr_tc;
    logic [TW-1:0]       tmr_last;

    assign tmr_last = (state_q == ST_GUARD) ? GUARD_LAST : DIV_LAST;

    // Every terminal count is a state change, so it doubles as the timer restart.
    seg_scan_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_tc),
        .last (tmr_last),
        .tc   (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_GUARD;
            idx_q      <= '0;
            pending_q  <= {DIGITS{SEG_BLANK}};
            shadow_q   <= {DIGITS{SEG_BLANK}};
            pend_vld_q <= 1'b0;
            seg_q      <= SEG_BLANK;
            sel_q      <= '1;
            frame_q    <= 1'b0;
            upd_ack_q  <= 1'b0;
        end else begin
            frame_q   <= 1'b0;
            upd_ack_q <= 1'b0;

            unique case (state_q)
                ST_GUARD: begin
                    if (tmr_tc) begin
                        state_q <= ST_SHOW;
                        sel_q   <= ~(DIGITS'(1) << idx_q);
                        seg_q   <= shadow_q[8*idx_q +: 8];
                    end
                end
                ST_SHOW: begin
                    if (tmr_tc) begin
                        state_q <= ST_GUARD;
                        sel_q   <= '1;
                        seg_q   <= SEG_BLANK;
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= '0;
                            frame_q <= 1'b1;
                            if (pend_vld_q) begin
                                shadow_q   <= pending_q;
                                pend_vld_q <= 1'b0;
                                upd_ack_q  <= 1'b1;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_GUARD;
                end
            endcase

            // Placed after the commit so a write on the boundary edge keeps pend_vld set.
            if (bus.code_vld) begin
                pending_q  <= bus.code;
                pend_vld_q <= 1'b1;
            end
        end
    end

    assign bus.seg     = seg_q;
    assign bus.sel     = sel_q;
    assign bus.frame   = frame_q;
    assign bus.upd_ack = upd_ack_q;

endmodule

// File: tb/tb_seg_scan.sv
// Randomised bench for seg_scan: a cycle-position model predicts every output each cycle.
module tb_seg_scan;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DIV    = 4;
    localparam int unsigned GUARD  = 2;
    localparam int unsigned SLOT   = GUARD + DIV;
    localparam int unsigned PERIOD = DIGITS * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg_scan_if #(.DIGITS(DIGITS)) bus ();

    seg_scan #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .GUARD  (GUARD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: edges since reset release, plus the two buffers as seen from outside.
    int unsigned         n_edges;
    logic [8*DIGITS-1:0] m_pend;
    logic [8*DIGITS-1:0] m_shadow;
    logic                m_pvld;
    logic [7:0]          e_seg;
    logic [DIGITS-1:0]   e_sel;
    logic                e_frame;
    logic                e_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h (edge %0d, t=%0t)", tag, got, exp, n_edges, $time);
        end
    endtask

    task automatic model_reset();
        n_edges  = 0;
        m_pend   = '1;
        m_shadow = '1;
        m_pvld   = 1'b0;
        e_seg    = 8'hff;
        e_sel    = '1;
        e_frame  = 1'b0;
        e_ack    = 1'b0;
    endtask

    task automatic model_edge(input logic vld, input logic [8*DIGITS-1:0] c);
        int unsigned p;
        int unsigned slot;
        int unsigned off;
        n_edges++;
        e_frame = (n_edges % PERIOD) == 0;
        e_ack   = 1'b0;
        if (e_frame && m_pvld) begin
            m_shadow = m_pend;
            m_pvld   = 1'b0;
            e_ack    = 1'b1;
        end
        if (vld) begin
            m_pend = c;
            m_pvld = 1'b1;
        end
        p    = n_edges % PERIOD;
        slot = p / SLOT;
        off  = p % SLOT;
        if (off >= GUARD) begin
            e_sel = ~(DIGITS'(1) << slot);
            e_seg = m_shadow[8*slot +: 8];
        end else begin
            e_sel = '1;
            e_seg = 8'hff;
        end
    endtask

    task automatic check_outputs();
        check("seg", 32'(bus.seg), 32'(e_seg));
        check("sel", 32'(bus.sel), 32'(e_sel));
        check("frame", 32'(bus.frame), 32'(e_frame));
        check("upd_ack", 32'(bus.upd_ack), 32'(e_ack));
        check("one_cold", 32'($countones(~bus.sel) <= 1), 32'(1));
        check("blank_dark", 32'((bus.sel != '1) || (bus.seg == 8'hff)), 32'(1));
    endtask

    // Called at a negedge: present inputs, take one rising edge, check at the next negedge.
    task automatic step(input logic vld, input logic [8*DIGITS-1:0] c);
        bus.code_vld = vld;
        bus.code     = c;
        @(posedge clk);
        model_edge(vld, c);
        @(negedge clk);
        bus.code_vld = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, '0);
    endtask

    task automatic idle_until(input int unsigned phase);
        for (int i = 0; i < int'(PERIOD) && (n_edges % PERIOD) != phase; i++) step(1'b0, '0);
    endtask

    // Asynchronous reset applied away from the clock edge; outputs must go dark at once.
    task automatic do_reset();
        bus.code_vld = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_seg", 32'(bus.seg), 32'h0000_00ff);
        check("rst_sel", 32'(bus.sel), 32'h0000_000f);
        check("rst_frame", 32'(bus.frame), 32'(0));
        check("rst_ack", 32'(bus.upd_ack), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.code     = '0;
        bus.code_vld = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Idle scan: blank segments, rotating select, frame every PERIOD.
        idle(2 * PERIOD + 2);

        // Load and hold.
        step(1'b1, 32'h99b0a4f9);
        idle(2 * PERIOD);

        // Two writes in one frame: only the second commits.
        idle_until(1);
        step(1'b1, 32'hc0c0c0c0);
        idle(5);
        step(1'b1, 32'h92929292);
        idle(2 * PERIOD);

        // Write landing on the boundary edge while an older value is pending.
        idle_until(3);
        step(1'b1, 32'h8288f8c6);
        idle_until(PERIOD - 1);
        step(1'b1, 32'ha1868e83);
        idle(2 * PERIOD);

        // Reset during SHOW of digit 2 with a write pending.
        idle_until(2 * SLOT + GUARD);
        step(1'b1, 32'h12345678);
        step(1'b0, '0);
        do_reset();
        idle(PERIOD + SLOT);

        // Random writes.
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 15) == 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
